sysbus_mem_responder: RTL and testbench

Memory-side responder for the 64-bit Sysbus request/response protocol that the core's memory controller drives as initiator. It accepts block read and block write requests, keeps an internal word array as backing store, and returns 8-beat read bursts. Read responses use a configurable access latency and respect respack back-pressure. It is used as a synthesizable memory model for core-level simulation and as the template for an on-chip RAM slave.

---
 rtl/sysbus_mem_responder.sv | 104 ++++++++++
 tb/tb_sysbus_mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus block-read/write memory responder with backdoor preload
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int BEATS = 8,
  parameter int ADDR_WORDS_LOG2 = 12,
  parameter int READ_LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0]  bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]   bus_reqtag,
  output logic                       bus_reqack,
  output logic                       bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]  bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]   bus_resptag,
  input  logic                       bus_respack,
  input  logic                       init_we,
  input  logic [ADDR_WORDS_LOG2-1:0] init_addr,
  input  logic [BUS_DATA_WIDTH-1:0]  init_data
);
  localparam int BW = $clog2(BEATS);
  localparam int KW = ADDR_WORDS_LOG2 - BW;
  localparam int CW = $clog2(READ_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_RESP} state_t;
  state_t state, state_n;
  logic [BW-1:0] beat, beat_n, beat_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] blk, blk_n;
  logic [BUS_TAG_WIDTH-1:0] tag_n;
  logic ack_n, respcyc_n, wr_en, last;
  logic [BUS_DATA_WIDTH-1:0] resp_n;
  logic [BUS_DATA_WIDTH-1:0] mem [2**ADDR_WORDS_LOG2];
  assign beat_inc = beat + 1'b1;
  assign last = beat == BW'(BEATS - 1);
  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n = state;
    beat_n = beat;
    cnt_n = cnt;
    blk_n = blk;
    tag_n = bus_resptag;
    ack_n = 1'b0;
    respcyc_n = bus_respcyc;
    resp_n = bus_resp;
    wr_en = 1'b0;
    case (state)
      IDLE: if (bus_reqcyc) begin
        blk_n = bus_req[ADDR_WORDS_LOG2+2:BW+3];
        tag_n = bus_reqtag;
        ack_n = 1'b1;
        beat_n = '0;
        cnt_n = CW'(READ_LATENCY - 1);
        state_n = bus_reqtag[BUS_TAG_WIDTH-1] ? WR_DATA : RD_WAIT;
      end
      WR_DATA: if (bus_reqcyc) begin
        wr_en = 1'b1;
        beat_n = beat_inc;
        state_n = last ? IDLE : WR_DATA;
      end
      RD_WAIT: begin
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
        state_n = cnt == '0 ? RD_RESP : RD_WAIT;
        respcyc_n = cnt == '0;
        resp_n = cnt == '0 ? mem[{blk, beat}] : bus_resp;
      end
      RD_RESP: if (bus_respack) begin
        beat_n = beat_inc;
        respcyc_n = !last;
        resp_n = last ? '0 : mem[{blk, beat_inc}];
        state_n = last ? IDLE : RD_RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      cnt <= '0;
      blk <= '0;
      bus_resptag <= '0;
      bus_reqack <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp <= '0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      cnt <= cnt_n;
      blk <= blk_n;
      bus_resptag <= tag_n;
      bus_reqack <= ack_n;
      bus_respcyc <= respcyc_n;
      bus_resp <= resp_n;
    end
  end
  // Backing store; the bus write is issued last so it wins a same-word collision
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
    if (wr_en) mem[{blk, beat}] <= bus_req;
  end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: directed scoreboard bench for sysbus_mem_responder
module tb_sysbus_mem_responder;
  logic clk = 1'b0, reset = 1'b1;
  logic bus_reqcyc = 1'b0, bus_respack = 1'b0, init_we = 1'b0;
  logic [63:0] bus_req = '0, init_data = '0, bus_resp;
  logic [12:0] bus_reqtag = '0, bus_resptag;
  logic [11:0] init_addr = '0;
  logic bus_reqack, bus_respcyc;
  logic [63:0] model [4096];
  typedef struct {logic [63:0] d; logic [12:0] t;} exp_t;
  exp_t q[$];
  int n = 0, fails = 0;

  sysbus_mem_responder dut (
    .clk(clk), .reset(reset), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    model[a] = d;
    tick();
    init_we = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, input logic [12:0] t);
    int k;
    bus_reqcyc = 1'b1; bus_req = a; bus_reqtag = t;
    tick();
    bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
    chk("rd_reqack", bus_reqack, 1);
    for (int b = 0; b < 8; b++) q.push_back('{model[{a[14:6], 3'(b)}], t});
    k = 1;
    while (!bus_respcyc && k < 50) begin
      tick();
      k++;
      chk("reqack_one_cycle", bus_reqack, 0);
    end
    chk("read_latency", k, 5);
  endtask

  task automatic collect(input int mode, input int nb);
    int i, got;
    i = 0; got = 0;
    while (got < nb && i < 200) begin
      bus_respack = mode == 0 ? 1'b1 : (i % 3 == 0);
      if (bus_respcyc) begin
        chk("beat_data", bus_resp, q[0].d);
        chk("beat_tag", bus_resptag, q[0].t);
        if (bus_respack) begin
          void'(q.pop_front());
          got++;
        end
      end
      tick();
      i++;
    end
    bus_respack = 1'b0;
    chk("beats_received", got, nb);
  endtask

  task automatic wr(input logic [63:0] a, input logic [12:0] t, input logic [63:0] d0);
    bus_reqcyc = 1'b1; bus_req = a; bus_reqtag = t;
    tick();
    bus_reqtag = '0;
    chk("wr_reqack", bus_reqack, 1);
    for (int i = 0; i < 8; i++) begin
      bus_reqcyc = 1'b1; bus_req = d0 + 64'(i);
      tick();
      model[{a[14:6], 3'(i)}] = d0 + 64'(i);
      if (i == 2 || i == 5) begin
        bus_reqcyc = 1'b0; bus_req = '0;
        tick();
      end
    end
    bus_reqcyc = 1'b0; bus_req = '0;
    tick();
    chk("wr_no_resp", bus_respcyc, 0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_reqack", bus_reqack, 0);
      chk("idle_respcyc", bus_respcyc, 0);
      chk("idle_resp", bus_resp, 0);
      chk("idle_resptag", bus_resptag, 0);
    end
    for (int i = 0; i < 8; i++) preload(12'h200 + 12'(i), 64'hA0 + 64'(i));
    for (int i = 0; i < 8; i++) preload(12'(i), 64'hC0 + 64'(i));
    rd(64'h1008, 13'h0100);
    collect(0, 8);
    chk("rd_done_respcyc", bus_respcyc, 0);
    chk("rd_done_resp", bus_resp, 0);
    rd(64'h1008, 13'h0100);
    collect(1, 8);
    chk("bp_done_respcyc", bus_respcyc, 0);
    wr(64'h2040, 13'h1100, 64'h11);
    rd(64'h2040, 13'h0100);
    collect(0, 8);
    chk("wr_rd_done", bus_respcyc, 0);
    chk("wrap_model", model[0], 64'hC0);
    rd(64'h8000, 13'h0200);
    collect(0, 8);
    rd(64'h0000, 13'h0200);
    collect(0, 8);
    rd(64'h1008, 13'h0300);
    collect(0, 2);
    chk("third_beat", bus_resp, 64'hA2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    chk("rst_respcyc", bus_respcyc, 0);
    chk("rst_resp", bus_resp, 0);
    chk("rst_resptag", bus_resptag, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_respcyc", bus_respcyc, 0);
      chk("post_rst_reqack", bus_reqack, 0);
    end
    rd(64'h1008, 13'h0100);
    collect(0, 8);
    chk("final_respcyc", bus_respcyc, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
